// File: rtl/pcie_replay_buffer.sv
// PCIe DLL replay buffer: sequences and stores TLPs and serializes them as 16-bit words.
// ACK retires stored TLPs; NAK or replay-timer expiry retransmits everything still unacknowledged.
module pcie_replay_buffer (
    input  logic         busy_n,
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   ack_nack,
    input  logic [11:0]  seq,
    input  logic         tim_out,
    output logic         ready,
    input  logic         we,
    input  logic [127:0] din,
    output logic [15:0]  dout
);
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEQ_W  = 12;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned WORD_W = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TX     = 2'd1;
    localparam logic [1:0] REPLAY = 2'd2;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];

    logic [1:0]        state, state_nx;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0]  tx_ptr, tx_ptr_nx, word_idx, word_idx_nx;
    logic [CNT_W-1:0]  count, count_nx, rem, rem_nx, drop;
    logic [SEQ_W-1:0]  next_seq, next_seq_nx;
    logic              ready_nx, mem_we;
    logic [WORD_W-1:0] dout_nx;

    // Number of oldest entries covered by seq: stop at the first entry that lies ahead of it.
    always_comb begin
        logic             run;
        logic [PTR_W-1:0] p;
        logic [SEQ_W-1:0] diff;
        drop = '0;
        run  = 1'b1;
        p    = '0;
        diff = '0;
        for (int i = 0; i < DEPTH; i++) begin
            p    = rd_ptr + PTR_W'(i);
            diff = seq - mem_seq[p];
            if (run && (CNT_W'(i) < count) && !diff[SEQ_W-1]) begin
                drop = drop + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nx    = state;
        rd_ptr_nx   = rd_ptr;
        wr_ptr_nx   = wr_ptr;
        count_nx    = count;
        next_seq_nx = next_seq;
        tx_ptr_nx   = tx_ptr;
        word_idx_nx = word_idx;
        rem_nx      = rem;
        ready_nx    = ready;
        dout_nx     = dout;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                dout_nx  = '0;
                ready_nx = (count != CNT_W'(DEPTH));
                if (ack_nack == 2'b10) begin
                    rd_ptr_nx = rd_ptr + PTR_W'(drop);
                    count_nx  = count - drop;
                    ready_nx  = 1'b1;
                    if (count_nx != '0) begin
                        state_nx    = REPLAY;
                        tx_ptr_nx   = rd_ptr_nx;
                        rem_nx      = count_nx;
                        word_idx_nx = '0;
                        ready_nx    = 1'b0;
                    end
                end else if (tim_out) begin
                    if (count != '0) begin
                        state_nx    = REPLAY;
                        tx_ptr_nx   = rd_ptr;
                        rem_nx      = count;
                        word_idx_nx = '0;
                        ready_nx    = 1'b0;
                    end
                end else if (ack_nack == 2'b01) begin
                    rd_ptr_nx = rd_ptr + PTR_W'(drop);
                    count_nx  = count - drop;
                    ready_nx  = (count_nx != CNT_W'(DEPTH));
                end else if (we && ready) begin
                    // Word 0 goes out straight from din; the rest come from storage.
                    mem_we      = 1'b1;
                    wr_ptr_nx   = wr_ptr + PTR_W'(1);
                    count_nx    = count + CNT_W'(1);
                    next_seq_nx = next_seq + SEQ_W'(1);
                    state_nx    = TX;
                    tx_ptr_nx   = wr_ptr;
                    word_idx_nx = PTR_W'(1);
                    rem_nx      = CNT_W'(1);
                    ready_nx    = 1'b0;
                    dout_nx     = din[DATA_W-1 -: WORD_W];
                end
            end
            TX, REPLAY: begin
                ready_nx = 1'b0;
                if (busy_n) begin
                    if (rem == '0) begin
                        dout_nx  = '0;
                        state_nx = IDLE;
                        ready_nx = (count != CNT_W'(DEPTH));
                    end else begin
                        dout_nx     = mem_data[tx_ptr][{3'd7 - word_idx, 4'd0} +: WORD_W];
                        word_idx_nx = word_idx + PTR_W'(1);
                        if (word_idx == PTR_W'(7)) begin
                            tx_ptr_nx = tx_ptr + PTR_W'(1);
                            rem_nx    = rem - CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            next_seq <= '0;
            tx_ptr   <= '0;
            word_idx <= '0;
            rem      <= '0;
            ready    <= 1'b0;
            dout     <= '0;
        end else begin
            state    <= state_nx;
            rd_ptr   <= rd_ptr_nx;
            wr_ptr   <= wr_ptr_nx;
            count    <= count_nx;
            next_seq <= next_seq_nx;
            tx_ptr   <= tx_ptr_nx;
            word_idx <= word_idx_nx;
            rem      <= rem_nx;
            ready    <= ready_nx;
            dout     <= dout_nx;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_data[wr_ptr] <= din;
            mem_seq[wr_ptr]  <= next_seq;
        end
    end
endmodule

// File: tb/tb_pcie_replay_buffer.sv
// Bench for pcie_replay_buffer: directed and random operations against a queue-based model.
module tb_pcie_replay_buffer;
    logic         busy_n   = 1'b1;
    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic [1:0]   ack_nack = 2'b00;
    logic [11:0]  seq      = '0;
    logic         tim_out  = 1'b0;
    logic         we       = 1'b0;
    logic [127:0] din      = '0;
    logic         ready;
    logic [15:0]  dout;

    pcie_replay_buffer dut (
        .busy_n(busy_n), .clk(clk), .reset_n(reset_n), .ack_nack(ack_nack), .seq(seq),
        .tim_out(tim_out), .ready(ready), .we(we), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [11:0]  sq;
    } ent_t;

    ent_t        mq[$];
    int unsigned mseq = 0;
    logic [15:0] expq[$];
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [127:0] SPEC_TLP = 128'h400000010000000ffdaff04012345678;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_words(input logic [127:0] d);
        for (int k = 0; k < 8; k++) expq.push_back(d[127-16*k -: 16]);
    endfunction

    function automatic void purge(input logic [11:0] s);
        while (mq.size() > 0 && ((int'(s) - int'(mq[0].sq) + 4096) % 4096) < 2048)
            void'(mq.pop_front());
    endfunction

    function automatic logic [11:0] pick_seq();
        int base = (mq.size() > 0) ? int'(mq[0].sq) : int'(mseq);
        if ($urandom_range(7) == 0) return 12'($urandom);
        return 12'(base + int'($urandom_range(10)) - 2);
    endfunction

    function automatic logic [127:0] rnd_tlp();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Follows expq word by word; a low busy_n holds the current word for that edge.
    task automatic run_stream(input string tag, input bit rnd, input int stall_at,
                              input int stall_len, input bit junk);
        int p = 0;
        int stalled = 0;
        int guard = 0;
        int last = expq.size() - 1;
        check({tag, "_dout"}, 32'(dout), 32'(expq[0]));
        check({tag, "_ready"}, 32'(ready), 32'(0));
        while (p < last) begin
            guard++;
            if (guard > 400) begin
                check({tag, "_bound"}, 32'(guard), 32'(0));
                break;
            end
            busy_n = 1'b1;
            if (p == stall_at && stalled < stall_len) begin
                busy_n = 1'b0;
                stalled++;
            end else if (rnd && $urandom_range(3) == 0) begin
                busy_n = 1'b0;
            end
            if (junk) begin
                we = 1'($urandom); din = rnd_tlp(); ack_nack = 2'($urandom);
                tim_out = 1'($urandom); seq = 12'($urandom);
            end
            @(posedge clk);
            if (busy_n) p++;
            @(negedge clk);
            check({tag, "_dout"}, 32'(dout), 32'(expq[p]));
            check({tag, "_ready"}, 32'(ready), (p == last) ? 32'(mq.size() < 8) : 32'(0));
        end
        busy_n = 1'b1; we = 1'b0; ack_nack = 2'b00; tim_out = 1'b0;
        expq.delete();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_ready", 32'(ready), 32'(0));
        @(negedge clk);
        reset_n = 1'b1; busy_n = 1'b1; we = 1'b0; ack_nack = 2'b00; tim_out = 1'b0;
        mq.delete(); mseq = 0;
        @(negedge clk);
        check("rst_rel_ready", 32'(ready), 32'(1));
        check("rst_rel_dout", 32'(dout), 32'(0));
    endtask

    task automatic op_write(input logic [127:0] d, input bit rnd, input int sa, input int sl);
        bit accept = (mq.size() < 8);
        we = 1'b1; din = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        if (accept) begin
            mq.push_back('{data: d, sq: 12'(mseq)});
            mseq = (mseq + 1) % 4096;
            push_words(d);
            expq.push_back(16'h0000);
            run_stream("tx", rnd, sa, sl, rnd);
        end else begin
            check("full_dout", 32'(dout), 32'(0));
            check("full_ready", 32'(ready), 32'(0));
        end
    endtask

    task automatic op_ack(input logic [11:0] s, input bit with_we);
        ack_nack = 2'b01; seq = s; we = with_we; din = rnd_tlp();
        @(posedge clk);
        @(negedge clk);
        ack_nack = 2'b00; we = 1'b0;
        purge(s);
        check("ack_dout", 32'(dout), 32'(0));
        check("ack_ready", 32'(ready), 32'(mq.size() < 8));
    endtask

    task automatic replay_or_idle(input string tag, input bit rnd);
        if (mq.size() > 0) begin
            expq.push_back(16'h0000);
            foreach (mq[i]) push_words(mq[i].data);
            expq.push_back(16'h0000);
            run_stream(tag, rnd, -1, 0, rnd);
        end else begin
            check({tag, "_idle_dout"}, 32'(dout), 32'(0));
            check({tag, "_idle_ready"}, 32'(ready), 32'(1));
        end
    endtask

    task automatic op_nak(input logic [11:0] s, input bit with_tim, input bit rnd);
        ack_nack = 2'b10; seq = s; tim_out = with_tim;
        @(posedge clk);
        @(negedge clk);
        ack_nack = 2'b00; tim_out = 1'b0;
        purge(s);
        replay_or_idle("nak", rnd);
    endtask

    task automatic op_tim(input bit rnd);
        tim_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tim_out = 1'b0;
        replay_or_idle("tim", rnd);
    endtask

    initial begin
        #1;
        check("por_dout", 32'(dout), 32'(0));
        check("por_ready", 32'(ready), 32'(0));
        @(negedge clk);
        do_reset();

        // Basic write, then the same TLP with a two-cycle stall on word 3.
        op_write(SPEC_TLP, 1'b0, -1, 0);
        op_write(SPEC_TLP, 1'b0, 3, 2);

        // ACK seq 1 over seq 0..2, then the timer replays only seq 2.
        do_reset();
        for (int i = 0; i < 3; i++) op_write(rnd_tlp(), 1'b0, -1, 0);
        op_ack(12'd1, 1'b0);
        op_tim(1'b0);

        // NAK seq 0 replays seq 1 and 2; NAK seq 2 empties the buffer silently.
        do_reset();
        for (int i = 0; i < 3; i++) op_write(rnd_tlp(), 1'b0, -1, 0);
        op_nak(12'd0, 1'b0, 1'b0);
        op_nak(12'd2, 1'b0, 1'b0);
        op_tim(1'b0);

        // Fill to 8, ninth write ignored, ACK 0 frees one slot for seq 8.
        do_reset();
        for (int i = 0; i < 9; i++) op_write(rnd_tlp(), 1'b0, -1, 0);
        op_ack(12'd0, 1'b0);
        op_write(rnd_tlp(), 1'b0, -1, 0);
        op_ack(12'd7, 1'b0);
        op_tim(1'b0);
        op_ack(12'd8, 1'b0);
        op_tim(1'b0);

        // Reset in the middle of a transmission.
        we = 1'b1; din = SPEC_TLP;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        check("midrst_word0", 32'(dout), 32'h4000);
        repeat (3) @(negedge clk);
        do_reset();
        op_tim(1'b0);

        // Random mix with stalls and ignored inputs during transmission.
        for (int n = 0; n < 120; n++) begin
            int r = int'($urandom_range(9));
            if (r <= 4 || r == 9) op_write(rnd_tlp(), 1'b1, -1, 0);
            else if (r <= 6) op_ack(pick_seq(), 1'($urandom));
            else if (r == 7) op_nak(pick_seq(), 1'($urandom), 1'b1);
            else op_tim(1'b1);
        end

        // Walk next_seq up to 4095, then cross the wrap.
        do_reset();
        while (mseq != 4095) begin
            if (mq.size() == 7) op_ack(mq[$].sq, 1'b0);
            else op_write(rnd_tlp(), 1'b0, -1, 0);
        end
        op_ack(12'(mseq - 1), 1'b0);
        op_write(rnd_tlp(), 1'b0, -1, 0);
        op_write(rnd_tlp(), 1'b0, -1, 0);
        op_ack(12'd0, 1'b0);
        op_tim(1'b0);

        // NAK beats tim_out; ACK beats we.
        op_write(rnd_tlp(), 1'b0, -1, 0);
        op_write(rnd_tlp(), 1'b0, -1, 0);
        op_nak(12'd1, 1'b1, 1'b0);
        op_ack(12'd1, 1'b1);
        op_tim(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
